value_stream_checker: RTL

Consumer-side checker for the 8-bit/64-bit output stream of the coverage-exporter test DUT, which emits one snapshot per cycle: a counter in `value64[7:0]` and `accumulator + counter` in `value`. It samples the stream and rebuilds the producer's counter and accumulator. It flags upper-bit, counter-step and accumulator-rule violations, and keeps error/sample statistics and first-error capture. It sits beside the DUT in the test top, fed directly from its output registers.

---
 rtl/value_stream_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/value_stream_checker.sv
// Consumer-side checker for the counter/accumulator snapshot stream: rebuilds the producer state
// and flags upper-bit, step and accumulator violations. Define VALUE_CHECKER_ACC_CHECK_EN to add
// the accumulator check.
module value_stream_checker #(
    parameter int unsigned ERR_CNT_W   = 16,
    parameter int unsigned SMP_CNT_W   = 32,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_value,
    input  logic [63:0]          in_value64,
    input  logic                 clear,
    output logic                 err_pulse,
    output logic [2:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [SMP_CNT_W-1:0] sample_count,
    output logic                 has_err,
    output logic [SMP_CNT_W-1:0] first_err_idx,
    output logic [2:0]           first_err_code
);

    typedef enum logic [1:0] {StIdle, StPrime, StCheck, StHalt} state_e;

    state_e     state;
    logic [7:0] c_obs;
    logic [7:0] c_prev;
    logic       checking;
    logic       accept;
    logic       upper_err;
    logic       step_err;
    logic       acc_err;
    logic [2:0] sample_code;

    assign c_obs     = in_value64[7:0];
    assign checking  = (state == StCheck);
    assign accept    = in_valid && (state != StHalt);
    assign upper_err = |in_value64[63:8];
    assign step_err  = checking && (c_obs != c_prev + 8'd1);

`ifdef VALUE_CHECKER_ACC_CHECK_EN
    logic [7:0] a_prev;
    logic [7:0] a_obs;
    logic [7:0] a_exp;

    assign a_obs = in_value - c_obs;

    always_comb begin
        a_exp = a_prev;
        if (c_prev[0] && c_prev[1]) begin
            a_exp = a_prev + 8'd1;
        end else if (c_prev[2] || c_prev[3]) begin
            a_exp = a_prev - 8'd1;
        end
    end

    // The accumulator rule is only meaningful when the counter stepped correctly.
    assign acc_err = checking && !step_err && (a_obs != a_exp);
`else
    assign acc_err = 1'b0;
`endif

    assign sample_code = {acc_err, step_err, upper_err};

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state          <= StIdle;
            c_prev         <= '0;
            err_pulse      <= 1'b0;
            err_code       <= '0;
            err_count      <= '0;
            sample_count   <= '0;
            has_err        <= 1'b0;
            first_err_idx  <= '0;
            first_err_code <= '0;
`ifdef VALUE_CHECKER_ACC_CHECK_EN
            a_prev         <= '0;
`endif
        end else begin
            err_pulse <= 1'b0;
            err_code  <= '0;

            case (state)
                StIdle, StPrime: if (in_valid) state <= StCheck;
                StCheck:         if (!in_valid) state <= StPrime;
                default:         state <= StHalt;
            endcase

            if (accept) begin
                c_prev <= c_obs;
`ifdef VALUE_CHECKER_ACC_CHECK_EN
                // Re-sync to the expected value so one corrupted sample flags only once.
                a_prev <= acc_err ? a_exp : a_obs;
`endif
                if (sample_count != '1) sample_count <= sample_count + SMP_CNT_W'(1);

                if (|sample_code) begin
                    err_pulse <= 1'b1;
                    err_code  <= sample_code;
                    if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
                    if (!has_err) begin
                        has_err        <= 1'b1;
                        first_err_idx  <= sample_count;
                        first_err_code <= sample_code;
                    end
                    if (STOP_ON_ERR) state <= StHalt;
                end
            end
        end
    end

endmodule
